// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
//   Pipelined barrel shifter. The IN_W-bit operand is extended to WIDTH bits
//   (sign-extended for SRA, zero-extended otherwise). It then passes through
//   SHW = log2(WIDTH) stages. Stage k shifts by 2^k when AMT[k] is set.
//   Supported operations: SLL, SRL, SRA and ROL. A valid/ready handshake
//   provides back-pressure, and bubbles collapse.
//
// Ports
//   CLK        clock, all state on posedge
//   RST_N      asynchronous active-low reset
//   FLUSH      synchronous flush, clears every stage valid
//   IN_VALID   operand valid          IN_READY   block can accept
//   A          operand [IN_W]         AMT        shift amount [SHW]
//   MODE       00 SLL, 01 SRL, 10 SRA, 11 ROL
//   TAG        sideband [TAG_W], returned with the result
//   OUT_VALID  Y/OUT_TAG valid        OUT_READY  downstream accepts
//   Y          result [WIDTH]         OUT_TAG    tag of the result
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int IN_W  = 16,
  parameter int TAG_W = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [IN_W-1:0]          A,
  input  logic [$clog2(WIDTH)-1:0] AMT,
  input  logic [1:0]               MODE,
  input  logic [TAG_W-1:0]         TAG,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         Y,
  output logic [TAG_W-1:0]         OUT_TAG
);

  localparam int SHW = $clog2(WIDTH);

  // One fixed-distance step of the selected operation.
  // Because SRA is arithmetic, it keeps replicating bit WIDTH-1 of the
  // extended value at every stage.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       m,
                                                  input int               s);
    case (m)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return WIDTH'($signed(v) >>> s);
      default: return (v << s) | (v >> (WIDTH - s));
    endcase
  endfunction

  logic [WIDTH-1:0] entry_data;

  always_comb begin
    entry_data = WIDTH'(A);
    if (MODE == 2'b10) entry_data = WIDTH'($signed(A));
  end

  // Reset also forces IN_READY low. Otherwise the empty pipe would look
  // ready while RST_N is held low.
  assign IN_READY = RST_N & ~FLUSH & pipe[0].adv;

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : pipe
      localparam int STEP = 1 << gi;

      logic               src_valid;
      logic [WIDTH-1:0]   src_data;
      logic [1:0]         src_mode;
      logic [SHW-1:gi]    src_amt;   // only the amount bits not yet consumed
      logic [TAG_W-1:0]   src_tag;
      logic [WIDTH-1:0]   shifted;
      logic               adv;

      logic               valid_reg;
      logic [WIDTH-1:0]   data_reg;
      logic [TAG_W-1:0]   tag_reg;

      if (gi == 0) begin : g_src
        assign src_valid = IN_VALID & IN_READY;
        assign src_data  = entry_data;
        assign src_mode  = MODE;
        assign src_amt   = AMT;
        assign src_tag   = TAG;
      end else begin : g_src
        assign src_valid = pipe[gi-1].valid_reg;
        assign src_data  = pipe[gi-1].data_reg;
        assign src_mode  = pipe[gi-1].g_carry.mode_reg;
        assign src_amt   = pipe[gi-1].g_carry.amt_reg;
        assign src_tag   = pipe[gi-1].tag_reg;
      end

      // A stage can take a new item when it is empty or its item moves on.
      if (gi == SHW - 1) begin : g_adv
        assign adv = ~valid_reg | OUT_READY;
      end else begin : g_adv
        assign adv = ~valid_reg | pipe[gi+1].adv;
      end

      assign shifted = src_amt[gi] ? shift_step(src_data, src_mode, STEP) : src_data;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          tag_reg   <= '0;
        end else begin
          if (FLUSH)
            valid_reg <= 1'b0;
          else if (adv)
            valid_reg <= src_valid;
          // Payload is loaded only with a real item, so a stalled output
          // never changes under a bubble.
          if (adv && src_valid) begin
            data_reg <= shifted;
            tag_reg  <= src_tag;
          end
        end
      end

      // Mode and remaining amount bits are needed only by downstream stages.
      if (gi < SHW - 1) begin : g_carry
        logic [1:0]        mode_reg;
        logic [SHW-1:gi+1] amt_reg;

        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) begin
            mode_reg <= '0;
            amt_reg  <= '0;
          end else if (adv && src_valid) begin
            mode_reg <= src_mode;
            amt_reg  <= src_amt[SHW-1:gi+1];
          end
        end
      end
    end
  endgenerate

  assign OUT_VALID = pipe[SHW-1].valid_reg;
  assign Y         = pipe[SHW-1].data_reg;
  assign OUT_TAG   = pipe[SHW-1].tag_reg;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe
//   Directed bench for barrel_shift_pipe with WIDTH=32, IN_W=16, TAG_W=4.
//   A negedge monitor keeps a queue of expected results. Entries are pushed
//   on accept and popped on the output handshake. Directed steps also check
//   hand-computed values, latency and handshake behaviour.
module tb_barrel_shift_pipe;

  localparam int WIDTH = 32;
  localparam int IN_W  = 16;
  localparam int TAG_W = 4;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              FLUSH = 1'b0;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic [IN_W-1:0]   A = '0;
  logic [4:0]        AMT = '0;
  logic [1:0]        MODE = '0;
  logic [TAG_W-1:0]  TAG = '0;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b1;
  logic [WIDTH-1:0]  Y;
  logic [TAG_W-1:0]  OUT_TAG;

  barrel_shift_pipe #(.WIDTH(WIDTH), .IN_W(IN_W), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .AMT(AMT), .MODE(MODE), .TAG(TAG),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Y(Y), .OUT_TAG(OUT_TAG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] y;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    acc_cnt = 0;
  int    out_cnt = 0;
  logic  prev_stall = 1'b0;
  logic [35:0] held = '0;
  logic  rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  // Reference: one whole-distance shift on the extended operand.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [4:0] amt,
                                        input logic [1:0] mode);
    logic [31:0] e;
    logic [63:0] d;
    e = (mode == 2'b10) ? {{16{a[15]}}, a} : {16'h0000, a};
    case (mode)
      2'b00:   return e << amt;
      2'b01:   return e >> amt;
      2'b10:   return 32'($signed(e) >>> amt);
      default: begin
        d = {e, e} << amt;
        return d[63:32];
      end
    endcase
  endfunction

  // Scoreboard and output-stability monitor.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", OUT_VALID, 1'b1);
        check("hold_data", {OUT_TAG, Y}, held);
      end
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("spurious_out", OUT_VALID, 1'b0);
        end else begin
          e = sb.pop_front();
          check("sb_out", {OUT_TAG, Y}, {e.tag, e.y});
          $display("out tag=%0d y=%h", OUT_TAG, Y);
          out_cnt++;
        end
      end
      if (FLUSH) sb.delete();
      if (IN_VALID && IN_READY) begin
        e.tag = TAG;
        e.y   = model(A, AMT, MODE);
        sb.push_back(e);
        acc_cnt++;
        $display("in  tag=%0d a=%h amt=%0d mode=%0d", TAG, A, AMT, MODE);
      end
      prev_stall = OUT_VALID && !OUT_READY && !FLUSH;
      held = {OUT_TAG, Y};
    end
  end

  always @(posedge CLK) begin
    if (rand_rdy) begin
      #1;
      OUT_READY = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Called at posedge+1. Returns at posedge+1 just after the accept edge.
  task automatic send(input logic [15:0] a, input logic [4:0] amt,
                      input logic [1:0] mode, input logic [3:0] tag);
    int n;
    n = 0;
    A = a; AMT = amt; MODE = mode; TAG = tag; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) check("send_timeout", IN_READY, 1'b1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic run_one(input logic [15:0] a, input logic [4:0] amt, input logic [1:0] mode,
                         input logic [3:0] tag, input logic [31:0] exp, input string name);
    int n;
    n = 0;
    send(a, amt, mode, tag);
    @(negedge CLK);
    while (!OUT_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check(name, {OUT_VALID, OUT_TAG, Y}, {1'b1, tag, exp});
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int base_acc;
    int base_out;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_in_ready", IN_READY, 1'b0);
    check("rst_out_valid", OUT_VALID, 1'b0);
    check("rst_y", Y, 32'h0);
    check("rst_tag", OUT_TAG, 4'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // 1: SLL latency, 5 cycles from accept.
    A = 16'h8001; AMT = 5'd15; MODE = 2'b00; TAG = 4'd1; IN_VALID = 1'b1;
    @(negedge CLK);
    check("t1_in_ready", IN_READY, 1'b1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("t1_not_yet", OUT_VALID, 1'b0);
    @(negedge CLK);
    check("t1_sll", {OUT_VALID, OUT_TAG, Y}, {1'b1, 4'd1, 32'h4000_8000});
    @(posedge CLK);
    #1;

    // 2, 3 and boundary amounts.
    run_one(16'h8000, 5'd4,  2'b10, 4'd2, 32'hFFFF_F800, "t2_sra_neg");
    run_one(16'h8000, 5'd4,  2'b01, 4'd3, 32'h0000_0800, "t2_srl");
    run_one(16'h8001, 5'd20, 2'b11, 4'd4, 32'h0010_0008, "t3_rol20");
    run_one(16'h8001, 5'd0,  2'b11, 4'd5, 32'h0000_8001, "t3_rol0");
    run_one(16'h8001, 5'd0,  2'b10, 4'd6, 32'hFFFF_8001, "amt0_sra");
    run_one(16'h4000, 5'd3,  2'b10, 4'd7, 32'h0000_0800, "sra_pos");
    run_one(16'h0001, 5'd31, 2'b00, 4'd8, 32'h8000_0000, "sll31");
    run_one(16'h8000, 5'd31, 2'b10, 4'd9, 32'hFFFF_FFFF, "sra31");
    run_one(16'h8000, 5'd17, 2'b11, 4'd10, 32'h0000_0001, "rol17_wrap");

    // 4: back-pressure. Five items fill the pipe, then IN_READY drops.
    base_acc = acc_cnt;
    base_out = out_cnt;
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++)
      send(16'h1000 + 16'(i), 5'(i), 2'(i), 4'(i));
    check("t4_acc5", acc_cnt - base_acc, 5);
    A = 16'h1005; AMT = 5'd5; MODE = 2'b01; TAG = 4'd5; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t4_full_ready", IN_READY, 1'b0);
    end
    check("t4_no_out", out_cnt - base_out, 0);
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    for (int i = 5; i < 8; i++)
      send(16'h1000 + 16'(i), 5'(i), 2'(i), 4'(i));
    drain();
    check("t4_out8", out_cnt - base_out, 8);

    // 5: flush with three in flight and a competing input.
    for (int i = 0; i < 3; i++)
      send(16'hA5A5, 5'(i + 1), 2'b00, 4'(11 + i));
    FLUSH = 1'b1;
    A = 16'h1234; AMT = 5'd1; MODE = 2'b00; TAG = 4'd14; IN_VALID = 1'b1;
    @(negedge CLK);
    check("t5_flush_ready", IN_READY, 1'b0);
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("t5_no_out", OUT_VALID, 1'b0);
    end
    @(posedge CLK);
    #1;
    run_one(16'h00FF, 5'd8, 2'b00, 4'd15, 32'h0000_FF00, "t5_after_flush");

    // 6: reset mid-stream, then random traffic against the model.
    rand_rdy = 1'b1;
    for (int i = 0; i < 6; i++)
      send(16'($urandom), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i));
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check("t6_rst_valid", OUT_VALID, 1'b0);
    check("t6_rst_y", Y, 32'h0);
    check("t6_rst_ready", IN_READY, 1'b0);
    rand_rdy = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #2;
    OUT_READY = 1'b1;
    RST_N = 1'b1;
    A = 16'hC003; AMT = 5'd2; MODE = 2'b10; TAG = 4'd3; IN_VALID = 1'b1;
    @(negedge CLK);
    check("t6_first_accept", IN_READY, 1'b1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++)
      send(16'($urandom), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i));
    rand_rdy = 1'b0;
    @(posedge CLK);
    #2;
    OUT_READY = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
